// File: rtl/hs32_sram_pkg.sv
// Shared types and constants for the HS32 SRAM arbiter.
// FSM states, grant identifiers and the full-word write mask.
package hs32_sram_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      ACK
   } state_t;

   localparam logic GNT_CORE = 1'b0;
   localparam logic GNT_WB   = 1'b1;

   localparam logic [3:0] FULL_MASK = 4'hF;

endpackage

// File: rtl/hs32_sram_arbiter_rr_arb2.sv
// Two-input round-robin arbiter, core vs Wishbone.
// On contention the side that did not win last time is granted.
module hs32_rr_arb2
   import hs32_sram_pkg::*;
(
   input  logic       req_core,
   input  logic       req_wb,
   input  logic       last_grant,
   input  logic       en,
   output logic [1:0] gnt
);

   // one-hot grant: bit 0 = core, bit 1 = wishbone
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req_core && req_wb) begin
            gnt = (last_grant == GNT_WB) ? 2'b01 : 2'b10;
         end else begin
            gnt = {req_wb, req_core};
         end
      end
   end

endmodule

// File: rtl/hs32_sram_arbiter.sv
// Shares one single-port SRAM between the HS32 core and the
// management Wishbone port with a fixed-latency access FSM.
module hs32_sram_arbiter
   import hs32_sram_pkg::*;
#(
   parameter int AW       = 8,
   parameter int SRAM_LAT = 1
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic          core_stb,
   input  logic          core_rw,
   input  logic [31:0]   core_addr,
   input  logic [31:0]   core_dtw,
   output logic [31:0]   core_dtr,
   output logic          core_ack,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic [3:0]    wb_sel_i,
   input  logic [31:0]   wb_adr_i,
   input  logic [31:0]   wb_dat_i,
   output logic [31:0]   wb_dat_o,
   output logic          wb_ack_o,
   output logic          sram_csb,
   output logic          sram_web,
   output logic [3:0]    sram_wmask,
   output logic [AW-1:0] sram_addr,
   output logic [31:0]   sram_din,
   input  logic [31:0]   sram_dout
);

   localparam logic [2:0] LAT_M1 = 3'(SRAM_LAT - 1);

   state_t        state;
   logic          last_grant;
   logic          gnt_id;
   logic          acc_we;
   logic          wb_abort;
   logic          wb_ack_r;
   logic [2:0]    cnt;

   logic          pend_core;
   logic [AW-1:0] core_addr_q;
   logic [31:0]   core_dtw_q;
   logic          core_rw_q;

   logic          req_core;
   logic          req_wb;
   logic [1:0]    gnt;
   logic [AW-1:0] c_addr;
   logic [31:0]   c_dtw;
   logic          c_rw;
   logic          unused_addr_bits;

   assign req_core = core_stb | pend_core;
   assign req_wb   = wb_cyc_i & wb_stb_i;

   // a fresh strobe is served directly; a pending one from the latch
   assign c_addr = pend_core ? core_addr_q : core_addr[AW+1:2];
   assign c_dtw  = pend_core ? core_dtw_q  : core_dtw;
   assign c_rw   = pend_core ? core_rw_q   : core_rw;

   // an ack is withheld once the master has abandoned the cycle
   assign wb_ack_o = wb_ack_r & wb_cyc_i;

   assign unused_addr_bits = ^{core_addr[31:AW+2], core_addr[1:0],
                               wb_adr_i[31:AW+2], wb_adr_i[1:0]};

   hs32_rr_arb2 u_arb (
      .req_core   (req_core),
      .req_wb     (req_wb),
      .last_grant (last_grant),
      .en         (state == IDLE),
      .gnt        (gnt)
   );

   // hold a core strobe until its ack so it survives a busy SRAM
   always_ff @(posedge clk) begin
      if (!rstb) begin
         pend_core   <= 1'b0;
         core_addr_q <= '0;
         core_dtw_q  <= '0;
         core_rw_q   <= 1'b0;
      end else if (core_ack) begin
         pend_core <= 1'b0;
      end else if (core_stb && !pend_core) begin
         pend_core   <= 1'b1;
         core_addr_q <= core_addr[AW+1:2];
         core_dtw_q  <= core_dtw;
         core_rw_q   <= core_rw;
      end
   end

   // access sequencer: grant, strobe SRAM, wait out latency, ack
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state      <= IDLE;
         last_grant <= GNT_WB;
         gnt_id     <= GNT_CORE;
         acc_we     <= 1'b0;
         wb_abort   <= 1'b0;
         cnt        <= '0;
         sram_csb   <= 1'b1;
         sram_web   <= 1'b1;
         sram_wmask <= '0;
         sram_addr  <= '0;
         sram_din   <= '0;
         core_ack   <= 1'b0;
         wb_ack_r   <= 1'b0;
         core_dtr   <= '0;
         wb_dat_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|gnt) begin
                  state    <= ACCESS;
                  sram_csb <= 1'b0;
                  wb_abort <= 1'b0;
                  if (gnt[0]) begin
                     gnt_id     <= GNT_CORE;
                     last_grant <= GNT_CORE;
                     acc_we     <= c_rw;
                     sram_web   <= ~c_rw;
                     sram_addr  <= c_addr;
                     sram_wmask <= c_rw ? FULL_MASK : 4'h0;
                     if (c_rw) sram_din <= c_dtw;
                  end else begin
                     gnt_id     <= GNT_WB;
                     last_grant <= GNT_WB;
                     acc_we     <= wb_we_i;
                     sram_web   <= ~wb_we_i;
                     sram_addr  <= wb_adr_i[AW+1:2];
                     sram_wmask <= wb_we_i ? wb_sel_i : 4'h0;
                     if (wb_we_i) sram_din <= wb_dat_i;
                  end
               end
            end
            ACCESS: begin
               sram_csb <= 1'b1;
               sram_web <= 1'b1;
               cnt      <= LAT_M1;
               state    <= WAIT;
            end
            WAIT: begin
               if (gnt_id == GNT_WB && !wb_cyc_i) wb_abort <= 1'b1;
               if (cnt == 3'd0) begin
                  state <= ACK;
                  if (gnt_id == GNT_CORE) begin
                     core_ack <= 1'b1;
                     if (!acc_we) core_dtr <= sram_dout;
                  end else begin
                     if (!acc_we) wb_dat_o <= sram_dout;
                     wb_ack_r <= wb_cyc_i & ~wb_abort;
                  end
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            ACK: begin
               core_ack <= 1'b0;
               wb_ack_r <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hs32_sram_arbiter.sv
// Directed bench for hs32_sram_arbiter, SRAM_LAT=1 and SRAM_LAT=3.
// Behavioural SRAM models sit behind each instance.
module tb_hs32_sram_arbiter;

   logic        clk = 1'b0;
   logic        rstb;
   logic        core_stb, core_rw;
   logic [31:0] core_addr, core_dtw;
   logic        wb_cyc, wb_stb, wb_we;
   logic [3:0]  wb_sel;
   logic [31:0] wb_adr, wb_dat;

   logic [31:0] core_dtr1, wb_dat_o1, sram_din1, sram_dout1;
   logic        core_ack1, wb_ack1, csb1, web1;
   logic [3:0]  wmask1;
   logic [7:0]  addr1;

   logic [31:0] core_dtr3, wb_dat_o3, sram_din3, sram_dout3;
   logic        core_ack3, wb_ack3, csb3, web3;
   logic [3:0]  wmask3;
   logic [7:0]  addr3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hs32_sram_arbiter #(.AW(8), .SRAM_LAT(1)) dut1 (
      .clk(clk), .rstb(rstb),
      .core_stb(core_stb), .core_rw(core_rw),
      .core_addr(core_addr), .core_dtw(core_dtw),
      .core_dtr(core_dtr1), .core_ack(core_ack1),
      .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
      .wb_sel_i(wb_sel), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
      .wb_dat_o(wb_dat_o1), .wb_ack_o(wb_ack1),
      .sram_csb(csb1), .sram_web(web1), .sram_wmask(wmask1),
      .sram_addr(addr1), .sram_din(sram_din1), .sram_dout(sram_dout1)
   );

   hs32_sram_arbiter #(.AW(8), .SRAM_LAT(3)) dut3 (
      .clk(clk), .rstb(rstb),
      .core_stb(core_stb), .core_rw(core_rw),
      .core_addr(core_addr), .core_dtw(core_dtw),
      .core_dtr(core_dtr3), .core_ack(core_ack3),
      .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
      .wb_sel_i(wb_sel), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
      .wb_dat_o(wb_dat_o3), .wb_ack_o(wb_ack3),
      .sram_csb(csb3), .sram_web(web3), .sram_wmask(wmask3),
      .sram_addr(addr3), .sram_din(sram_din3), .sram_dout(sram_dout3)
   );

   // SRAM models: masked write, read data after the given latency
   logic [31:0] mem1 [0:255];
   logic [31:0] mem3 [0:255];
   logic [31:0] rd1, p3a, p3b, p3c;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem1[i] = '0;
         mem3[i] = '0;
      end
      rd1 = '0; p3a = '0; p3b = '0; p3c = '0;
   end

   always @(posedge clk) begin
      if (!csb1) begin
         if (!web1) begin
            for (int b = 0; b < 4; b++)
               if (wmask1[b]) mem1[addr1][8*b +: 8] <= sram_din1[8*b +: 8];
         end else begin
            rd1 <= mem1[addr1];
         end
      end
   end
   assign sram_dout1 = rd1;

   always @(posedge clk) begin
      if (!csb3) begin
         if (!web3) begin
            for (int b = 0; b < 4; b++)
               if (wmask3[b]) mem3[addr3][8*b +: 8] <= sram_din3[8*b +: 8];
         end else begin
            p3a <= mem3[addr3];
         end
      end
      p3b <= p3a;
      p3c <= p3b;
   end
   assign sram_dout3 = p3c;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic core_req(input logic rw, input logic [31:0] a,
                           input logic [31:0] d);
      core_stb  = 1'b1;
      core_rw   = rw;
      core_addr = a;
      core_dtw  = d;
   endtask

   task automatic do_reset();
      rstb = 1'b0;
      tick();
      rstb = 1'b1;
   endtask

   int cc, wc, exp_side, n;
   logic fire;

   initial begin
      rstb = 1'b0;
      core_stb = 0; core_rw = 0; core_addr = 0; core_dtw = 0;
      wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 0;
      wb_adr = 0; wb_dat = 0;
      tick(); tick(); tick();

      chk("rst_csb", 32'(csb1), 1);
      chk("rst_web", 32'(web1), 1);
      chk("rst_wmask", 32'(wmask1), 0);
      chk("rst_addr", 32'(addr1), 0);
      chk("rst_din", sram_din1, 0);
      chk("rst_core_ack", 32'(core_ack1), 0);
      chk("rst_wb_ack", 32'(wb_ack1), 0);
      chk("rst_core_dtr", core_dtr1, 0);
      chk("rst_wb_dat", wb_dat_o1, 0);
      rstb = 1'b1;
      tick();

      // core write 0xCAFE to 0x14
      core_req(1'b1, 32'h14, 32'h0000CAFE);
      tick();
      core_stb = 1'b0;
      chk("wr_csb", 32'(csb1), 0);
      chk("wr_web", 32'(web1), 0);
      chk("wr_addr", 32'(addr1), 5);
      chk("wr_wmask", 32'(wmask1), 32'hF);
      chk("wr_din", sram_din1, 32'h0000CAFE);
      tick();
      chk("wr_wait_csb", 32'(csb1), 1);
      chk("wr_wait_ack", 32'(core_ack1), 0);
      tick();
      chk("wr_ack", 32'(core_ack1), 1);
      tick();
      chk("wr_ack_clr", 32'(core_ack1), 0);

      // core read back
      core_req(1'b0, 32'h14, 32'h0);
      tick();
      core_stb = 1'b0;
      chk("rd_csb", 32'(csb1), 0);
      chk("rd_web", 32'(web1), 1);
      tick(); tick();
      chk("rd_ack", 32'(core_ack1), 1);
      chk("rd_dtr", core_dtr1, 32'h0000CAFE);
      tick();

      // wishbone byte write, lane 1 only
      wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_sel = 4'b0010;
      wb_adr = 32'h14; wb_dat = 32'hAABBCCDD;
      tick();
      chk("wbw_wmask", 32'(wmask1), 32'h2);
      chk("wbw_web", 32'(web1), 0);
      chk("wbw_addr", 32'(addr1), 5);
      tick(); tick();
      chk("wbw_ack", 32'(wb_ack1), 1);
      chk("wbw_core_ack", 32'(core_ack1), 0);
      chk("wbw_dat_o", wb_dat_o1, 0);
      wb_cyc = 0; wb_stb = 0; wb_we = 0;
      tick();
      chk("wbw_dtr_kept", core_dtr1, 32'h0000CAFE);

      // wishbone read through an aliased address
      wb_cyc = 1; wb_stb = 1; wb_adr = 32'h414;
      tick();
      chk("wbr_addr", 32'(addr1), 5);
      tick(); tick();
      chk("wbr_ack", 32'(wb_ack1), 1);
      chk("wbr_dat", wb_dat_o1, 32'h0000CCFE);
      wb_cyc = 0; wb_stb = 0;
      tick();

      core_req(1'b0, 32'h14, 32'h0);
      tick();
      core_stb = 1'b0;
      tick(); tick();
      chk("merge_ack", 32'(core_ack1), 1);
      chk("merge_dtr", core_dtr1, 32'h0000CCFE);
      tick();

      // contention right after reset: core first
      do_reset();
      core_req(1'b0, 32'h14, 32'h0);
      wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h18;
      tick();
      core_stb = 1'b0;
      chk("ct_first_addr", 32'(addr1), 5);
      tick(); tick();
      chk("ct_core_ack", 32'(core_ack1), 1);
      chk("ct_wb_early", 32'(wb_ack1), 0);
      tick(); tick();
      chk("ct_second_addr", 32'(addr1), 6);
      chk("ct_second_csb", 32'(csb1), 0);
      tick();
      chk("ct_wb_n6", 32'(wb_ack1), 0);
      tick();
      chk("ct_wb_ack", 32'(wb_ack1), 1);
      chk("ct_core_n7", 32'(core_ack1), 0);
      wb_cyc = 0; wb_stb = 0;
      tick();

      // continuous contention, 6 requests per side
      cc = 0; wc = 0; exp_side = 0; fire = 1'b0;
      core_req(1'b0, 32'h20, 32'h0);
      wb_cyc = 1; wb_stb = 1; wb_adr = 32'h24;
      n = 0;
      while ((cc < 6 || wc < 6) && n < 200) begin
         tick();
         n++;
         core_stb = fire;
         fire = 1'b0;
         chk("cc_both_ack", 32'(core_ack1 & wb_ack1), 0);
         if (core_ack1) begin
            chk("cc_order_core", 32'(exp_side), 0);
            exp_side = 1;
            cc++;
            if (cc < 6) fire = 1'b1;
         end
         if (wb_ack1) begin
            chk("cc_order_wb", 32'(exp_side), 1);
            exp_side = 0;
            wc++;
            if (wc == 6) wb_stb = 0;
         end
      end
      chk("cc_core_count", 32'(cc), 6);
      chk("cc_wb_count", 32'(wc), 6);
      core_stb = 0;
      tick();
      wb_cyc = 0; wb_stb = 0;
      tick(); tick(); tick(); tick();

      // wishbone abort with a core request queued behind it
      wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h18;
      tick();
      core_req(1'b0, 32'h14, 32'h0);
      tick();
      core_stb = 1'b0;
      wb_cyc = 0; wb_stb = 0;
      for (int k = 3; k <= 7; k++) begin
         tick();
         chk("ab_wb_ack", 32'(wb_ack1), 0);
         if (k < 7) chk("ab_core_early", 32'(core_ack1), 0);
      end
      chk("ab_core_ack", 32'(core_ack1), 1);
      chk("ab_core_dtr", core_dtr1, 32'h0000CCFE);
      tick();

      // reset while waiting on the SRAM
      core_req(1'b0, 32'h14, 32'h0);
      tick();
      core_stb = 1'b0;
      tick();
      rstb = 1'b0;
      tick();
      rstb = 1'b1;
      chk("mr_csb", 32'(csb1), 1);
      chk("mr_ack", 32'(core_ack1), 0);
      chk("mr_dtr", core_dtr1, 0);
      core_req(1'b0, 32'h14, 32'h0);
      tick();
      core_stb = 1'b0;
      chk("mr_idle_access", 32'(csb1), 0);
      tick(); tick();
      chk("mr_after_ack", 32'(core_ack1), 1);
      chk("mr_after_dtr", core_dtr1, 32'h0000CCFE);
      tick();

      // SRAM_LAT=3 instance: write then read
      do_reset();
      core_req(1'b1, 32'h30, 32'h0000CAFE);
      tick();
      core_stb = 1'b0;
      chk("l3_csb", 32'(csb3), 0);
      chk("l3_addr", 32'(addr3), 12);
      tick(); tick(); tick();
      chk("l3_wr_n4", 32'(core_ack3), 0);
      tick();
      chk("l3_wr_ack", 32'(core_ack3), 1);
      tick();
      core_req(1'b0, 32'h30, 32'h0);
      tick();
      core_stb = 1'b0;
      tick(); tick(); tick();
      chk("l3_rd_n4", 32'(core_ack3), 0);
      tick();
      chk("l3_rd_ack", 32'(core_ack3), 1);
      chk("l3_rd_dtr", core_dtr3, 32'h0000CAFE);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
